// File: rtl/uart_core_if.sv
// Bus-side signal bundle between the memory controller's UART registers and uart_core.
interface uart_core_if;
    logic        tx_send;
    logic [31:0] tx_data;
    logic        rx_clear;
    logic        rx_pin;
    logic        tx_pin;
    logic        busy;
    logic        rx_flag;
    logic [31:0] rx_data;

    modport master (
        output tx_send, tx_data, rx_clear, rx_pin,
        input  tx_pin, busy, rx_flag, rx_data
    );

    modport slave (
        input  tx_send, tx_data, rx_clear, rx_pin,
        output tx_pin, busy, rx_flag, rx_data
    );
endinterface

// File: rtl/uart_core.sv
// 8N1 UART transceiver: independent TX and RX FSMs sharing one bit-period parameter.
//   state   | meaning
//   S_IDLE  | line idle; TX waits for tx_send, RX waits for synchronized low
//   S_START | start bit (TX drives 0; RX waits to mid-start and re-checks)
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | stop bit (TX drives 1; RX samples and validates)
module uart_core #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    uart_core_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_idx_q, tx_idx_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_pin_q, tx_pin_d;
    logic            busy_q, busy_d;

    state_e          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_idx_q, rx_idx_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_flag_q, rx_flag_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_s_q, rx_s_d;

    logic            unused_tx_hi;
    assign unused_tx_hi = ^bus.tx_data[31:8];

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_pin_d   = tx_pin_q;
        busy_d     = busy_q;
        case (tx_state_q)
            S_IDLE: begin
                tx_pin_d = 1'b1;
                if (bus.tx_send) begin
                    tx_shift_d = bus.tx_data[7:0];
                    busy_d     = 1'b1;
                    tx_pin_d   = 1'b0;
                    tx_cnt_d   = BIT_LAST;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = BIT_LAST;
                    tx_idx_d   = 3'd0;
                    tx_pin_d   = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = BIT_LAST;
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        tx_pin_d   = 1'b1;
                    end else begin
                        tx_idx_d   = tx_idx_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_pin_d   = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_IDLE;
                    busy_d     = 1'b0;
                    tx_pin_d   = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_meta_d  = bus.rx_pin;
        rx_s_d     = rx_meta_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        // Clear first so a valid stop bit in the same cycle overrides it.
        rx_flag_d  = rx_flag_q & ~bus.rx_clear;
        case (rx_state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = HALF_LAST;
                end
            end
            S_START: begin
                if (rx_cnt_q == '0) begin
                    if (rx_s_q) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_state_d = S_DATA;
                        rx_cnt_d   = BIT_LAST;
                        rx_idx_d   = 3'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
                    rx_cnt_d   = BIT_LAST;
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = S_IDLE;
                    if (rx_s_q) begin
                        rx_data_d = rx_shift_q;
                        rx_flag_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_pin_q   <= 1'b1;
            busy_q     <= 1'b0;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_flag_q  <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_pin_q   <= tx_pin_d;
            busy_q     <= busy_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_flag_q  <= rx_flag_d;
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
        end
    end

    assign bus.tx_pin  = tx_pin_q;
    assign bus.busy    = busy_q;
    assign bus.rx_flag = rx_flag_q;
    assign bus.rx_data = {24'b0, rx_data_q};
endmodule

// File: doc/uart_core.md
# uart_core

Byte-wide 8N1 UART transceiver that is the UART peripheral behind the memory controller's memory-mapped UART registers. It serialises the byte written to the UART TX address and deserialises bytes arriving on the RX pin. It also supplies the `busy`, `rx_flag` and `rx_data` values that the memory controller returns on bus reads. It consumes the controller's one-cycle `tx_send` and registered `rx_clear` strobes.

## Interface
- `CLKS_PER_BIT`, 434 — clock cycles per bit (50 MHz / 115200); legal range ≥ 4.
- `clk` in 1 — system clock; all logic on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `tx_send` in 1 — start transmission of `tx_data[7:0]`; one-cycle strobe.
- `tx_data` in 32 — bus write data; only bits [7:0] used.
- `rx_clear` in 1 — clear `rx_flag`; arrives one cycle after the bus read of RX data.
- `rx_pin` in 1 — serial input; asynchronous; idle high.
- `tx_pin` out 1 — serial output; idle high.
- `busy` out 1 — transmitter occupied.
- `rx_flag` out 1 — unread received byte present.
- `rx_data` out 32 — last received byte, zero-extended ({24'b0, byte}).

## Operation
- **Reset values:** `tx_pin`=1, `busy`=0, `rx_flag`=0, `rx_data`=0. Both FSMs go to IDLE and all counters clear. `rst` mid-frame aborts the frame; `tx_pin` returns high on the next edge.
- **Frame format:** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- **TX FSM states:** IDLE → START → DATA → STOP → IDLE.
  - IDLE: on `tx_send`=1, latch `tx_data[7:0]` into the shift register, set `busy`, and go to START.
  - `tx_send` while `busy`=1 is ignored; the latched byte is unchanged.
  - Each state holds `tx_pin` for exactly CLKS_PER_BIT cycles via a baud counter (0..CLKS_PER_BIT-1).
  - DATA uses a 3-bit bit index, wraps 7→STOP.
  - STOP drives 1; at the end of the stop period go to IDLE and clear `busy`.
- **RX path:** `rx_pin` passes through a 2-flop synchronizer (`rx_s`); the FSM uses only `rx_s`.
- **RX FSM states:** IDLE → START → DATA → STOP → IDLE.
  - IDLE: `rx_s`=0 → START and clear the baud counter.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample `rx_s`. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit) and shift right into bit 7, so the LSB arrives first; after 8 samples go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles. If 1, load `rx_data` and set `rx_flag`. If 0 (framing error), discard the byte and leave `rx_flag`/`rx_data` unchanged. Go to IDLE in both cases.
- **rx_flag:** set by a valid stop bit, cleared by `rx_clear`.
  - Simultaneous set and `rx_clear` → set wins (flag stays 1, new data).
- **Overrun:** a new valid byte while `rx_flag`=1 overwrites `rx_data`; the flag stays 1 and no error is reported.
- **Independence:** TX and RX are independent and full-duplex; loopback (`tx_pin` tied to `rx_pin`) must work.

## Timing
- **TX:** `tx_send` sampled at edge E.
  - `busy`=1 and `tx_pin`=0 (start bit) from edge E+1.
  - Data bit i occupies cycles E+1+(i+1)·CLKS_PER_BIT … +CLKS_PER_BIT-1.
  - Stop bit starts at E+1+9·CLKS_PER_BIT.
  - `busy` falls at E+1+10·CLKS_PER_BIT. A `tx_send` in that same cycle is accepted, giving back-to-back frames with no idle gap.
- **RX:** let edge F be the first edge at which `rx_s`=0 in IDLE (pin falling edge + 2 cycles).
  - Start check at F+CLKS_PER_BIT/2.
  - Bit i sampled at F+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT.
  - Stop bit sampled at F+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
  - `rx_flag`/`rx_data` are visible the cycle after the stop-bit sample.
  - RX returns to IDLE at mid-stop bit, so a start bit that follows immediately is detected.
- `rx_clear` takes effect at the edge where it is sampled; `rx_flag`=0 the following cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **TX 0xA5**, CLKS_PER_BIT=8: pulse `tx_send` with `tx_data`=0x123456A5 → `tx_pin` sequence 0,1,0,1,0,0,1,0,1,1, each level held 8 cycles. `busy` is high for exactly 80 cycles; the upper bits are ignored.
- **TX while busy:** send 0x3C, then pulse `tx_send` with 0xFF at cycle 20 → frame still carries 0x3C. A send in the cycle `busy` falls produces a second frame starting immediately.
- **RX 0x5A:** drive a clean 8N1 frame → `rx_data`=0x0000005A and `rx_flag`=1 one cycle after the stop sample. Pulse `rx_clear` → `rx_flag`=0 next cycle.
- **RX glitch and framing error:** a 2-cycle low pulse on `rx_pin` → no flag, FSM back in IDLE. A frame with stop bit=0 → `rx_flag` stays 0 and `rx_data` is unchanged.
- **Overrun and simultaneous events:** receive 0x11 without clearing, then 0x22 → `rx_data`=0x22, `rx_flag`=1. Assert `rx_clear` in the same cycle 0x33 completes → `rx_flag`=1, `rx_data`=0x33.
- **Loopback and reset:** with `tx_pin` tied to `rx_pin`, send 0xC3 → received 0xC3. Assert `rst` mid-TX-frame → next cycle `tx_pin`=1, `busy`=0, no spurious `rx_flag`.
